// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RET      = 2'd1,
    S_INT_PUSH = 2'd2,
    S_INT_VEC  = 2'd3
  } hz_state_e;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;
  localparam logic [1:0] PC_VEC = 2'b11;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: EX load target against the ID source fields.
module hazard_detect #(
  parameter int REG_AW = 2
) (
  input  logic              i_rd_en_E,
  input  logic [REG_AW-1:0] i_rd_E,
  input  logic [REG_AW-1:0] i_ra_D,
  input  logic [REG_AW-1:0] i_rb_D,
  input  logic              i_use_ra_D,
  input  logic              i_use_rb_D,
  output logic              o_load_use
);

  logic w_hit_a;
  logic w_hit_b;

  assign w_hit_a    = i_use_ra_D && (i_rd_E == i_ra_D);
  assign w_hit_b    = i_use_rb_D && (i_rd_E == i_rb_D);
  assign o_load_use = i_rd_en_E && (w_hit_a || w_hit_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/PC-select sequencer for load-use, branch, RET and interrupts.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RET_WAIT = 2,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [REG_AW-1:0] RA_D,
  input  logic [REG_AW-1:0] RB_D,
  input  logic              use_ra_D,
  input  logic              use_rb_D,
  input  logic              branch_taken_E,
  input  logic              is_ret_M,
  input  logic              intr_req,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_D,
  output logic              flush_E,
  output logic [1:0]        pc_sel,
  output logic              int_push,
  output logic              intr_ack
);

  localparam int CW = (RET_WAIT > 1) ? $clog2(RET_WAIT) : 1;

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic [CW-1:0] r_ret_cnt;
  logic [CW-1:0] w_ret_cnt_nxt;
  logic r_intr_pending;
  logic r_intr_q;
  logic r_intr_ack;
  logic w_load_use;
  logic w_intr_rise;

  hazard_detect #(.REG_AW(REG_AW)) u_hd (
    .i_rd_en_E  (rd_en_E),
    .i_rd_E     (rd_E),
    .i_ra_D     (RA_D),
    .i_rb_D     (RB_D),
    .i_use_ra_D (use_ra_D),
    .i_use_rb_D (use_rb_D),
    .o_load_use (w_load_use)
  );

  assign w_intr_rise = intr_req && !r_intr_q;
  assign intr_ack    = r_intr_ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_RUN;
      r_ret_cnt      <= '0;
      r_intr_pending <= 1'b0;
      r_intr_q       <= 1'b0;
      r_intr_ack     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ret_cnt  <= w_ret_cnt_nxt;
      r_intr_q   <= intr_req;
      r_intr_ack <= (r_state == S_INT_VEC);
      // a fresh edge beats the clear in S_INT_VEC
      if (w_intr_rise)
        r_intr_pending <= 1'b1;
      else if (r_state == S_INT_VEC)
        r_intr_pending <= 1'b0;
    end
  end

  always_comb begin
    stall_F       = 1'b0;
    stall_D       = 1'b0;
    flush_D       = 1'b0;
    flush_E       = 1'b0;
    pc_sel        = PC_SEQ;
    int_push      = 1'b0;
    w_state_nxt   = r_state;
    w_ret_cnt_nxt = r_ret_cnt;
    if (!reset) begin
      flush_D     = 1'b1;
      flush_E     = 1'b1;
      w_state_nxt = S_RUN;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (is_ret_M) begin
            stall_F       = 1'b1;
            flush_D       = 1'b1;
            flush_E       = 1'b1;
            w_state_nxt   = S_RET;
            w_ret_cnt_nxt = CW'(RET_WAIT - 1);
          end else if (branch_taken_E) begin
            pc_sel  = PC_BR;
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (w_load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
          end else if (r_intr_pending) begin
            w_state_nxt = S_INT_PUSH;
          end
        end
        S_RET: begin
          stall_F = 1'b1;
          flush_D = 1'b1;
          flush_E = 1'b1;
          if (r_ret_cnt == '0) begin
            stall_F     = 1'b0;
            pc_sel      = PC_RET;
            w_state_nxt = S_RUN;
          end else begin
            w_ret_cnt_nxt = r_ret_cnt - 1'b1;
          end
        end
        S_INT_PUSH: begin
          stall_F     = 1'b1;
          stall_D     = 1'b1;
          flush_E     = 1'b1;
          int_push    = 1'b1;
          w_state_nxt = S_INT_VEC;
        end
        S_INT_VEC: begin
          pc_sel      = PC_VEC;
          flush_D     = 1'b1;
          flush_E     = 1'b1;
          w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  a_no_ret_outside_run : assert property (
    @(posedge clk) disable iff (!reset)
    (r_state != S_RUN) |-> !is_ret_M
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random bench with a queue-based sequence model.
module tb_pipe_hazard_ctrl;

  localparam int RW = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en_E;
  logic [AW-1:0] rd_E;
  logic [AW-1:0] RA_D;
  logic [AW-1:0] RB_D;
  logic          use_ra_D;
  logic          use_rb_D;
  logic          branch_taken_E;
  logic          is_ret_M;
  logic          intr_req;
  logic          stall_F;
  logic          stall_D;
  logic          flush_D;
  logic          flush_E;
  logic [1:0]    pc_sel;
  logic          int_push;
  logic          intr_ack;

  pipe_hazard_ctrl #(.RET_WAIT(RW), .REG_AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .rd_en_E        (rd_en_E),
    .rd_E           (rd_E),
    .RA_D           (RA_D),
    .RB_D           (RB_D),
    .use_ra_D       (use_ra_D),
    .use_rb_D       (use_rb_D),
    .branch_taken_E (branch_taken_E),
    .is_ret_M       (is_ret_M),
    .intr_req       (intr_req),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .pc_sel         (pc_sel),
    .int_push       (int_push),
    .intr_ack       (intr_ack)
  );

  always #5 clk = ~clk;

  // {vec_marker, stall_F, stall_D, flush_D, flush_E, int_push, pc_sel}
  localparam logic [7:0] E_IDLE = 8'b0_0000_0_00;
  localparam logic [7:0] E_RST  = 8'b0_0011_0_00;
  localparam logic [7:0] E_HOLD = 8'b0_1011_0_00;
  localparam logic [7:0] E_RETL = 8'b0_0011_0_10;
  localparam logic [7:0] E_BR   = 8'b0_0011_0_01;
  localparam logic [7:0] E_LU   = 8'b0_1101_0_00;
  localparam logic [7:0] E_PUSH = 8'b0_1101_1_00;
  localparam logic [7:0] E_VEC  = 8'b1_0011_0_11;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_q[$];
  bit m_pend   = 0;
  bit m_prev   = 0;
  bit m_ack    = 0;
  bit m_ackok  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic lu;
    lu = rd_en_E && ((use_ra_D && rd_E == RA_D) ||
                     (use_rb_D && rd_E == RB_D));
    if (!reset)              return E_RST;
    if (m_q.size() > 0)      return m_q[0];
    if (is_ret_M)            return E_HOLD;
    if (branch_taken_E)      return E_BR;
    if (lu)                  return E_LU;
    return E_IDLE;
  endfunction

  task automatic model_clock();
    bit rise;
    bit ack_n;
    logic lu;
    lu = rd_en_E && ((use_ra_D && rd_E == RA_D) ||
                     (use_rb_D && rd_E == RB_D));
    if (!reset) begin
      m_q.delete();
      m_pend  = 0;
      m_prev  = 0;
      m_ack   = 0;
      m_ackok = 1;
      return;
    end
    rise  = intr_req && !m_prev;
    ack_n = 0;
    if (m_q.size() > 0) begin
      if (m_q[0][7]) begin
        ack_n  = 1;
        m_pend = 0;
      end
      void'(m_q.pop_front());
    end else if (is_ret_M) begin
      for (int i = 0; i < RW - 1; i++) m_q.push_back(E_HOLD);
      m_q.push_back(E_RETL);
    end else if (!branch_taken_E && !lu && m_pend) begin
      m_q.push_back(E_PUSH);
      m_q.push_back(E_VEC);
    end
    if (rise) m_pend = 1;
    m_prev = intr_req;
    m_ack  = ack_n;
  endtask

  task automatic step(input bit rst, input bit ld, input logic [1:0] rd,
                      input logic [1:0] ra, input logic [1:0] rb,
                      input bit ua, input bit ub, input bit br,
                      input bit ret, input bit req, input string tag);
    logic [7:0] e;
    logic [6:0] got;
    @(negedge clk);
    reset = rst; rd_en_E = ld; rd_E = rd; RA_D = ra; RB_D = rb;
    use_ra_D = ua; use_rb_D = ub; branch_taken_E = br;
    is_ret_M = ret; intr_req = req;
    #2;
    e   = model_out();
    got = {stall_F, stall_D, flush_D, flush_E, int_push, pc_sel};
    chk({tag, ".ctl"}, 32'(got), 32'(e[6:0]));
    if (m_ackok) chk({tag, ".ack"}, 32'(intr_ack), 32'(m_ack));
    @(posedge clk);
    model_clock();
  endtask

  task automatic idle(input int n, input bit req, input string tag);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, req, tag);
  endtask

  initial begin
    reset = 0; rd_en_E = 0; rd_E = 0; RA_D = 0; RB_D = 0;
    use_ra_D = 0; use_rb_D = 0; branch_taken_E = 0;
    is_ret_M = 0; intr_req = 0;
    idle(0, 0, "x");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
    step(0, 1, 1, 2, 1, 1, 1, 1, 0, 0, "rst_in");
    idle(2, 0, "post_rst");

    step(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, "lu_rb");
    step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, "lu_clr");
    step(1, 1, 2, 2, 3, 1, 0, 0, 0, 0, "lu_ra");
    step(1, 1, 2, 2, 2, 0, 0, 0, 0, 0, "lu_nouse");

    step(1, 1, 1, 0, 1, 0, 1, 1, 0, 0, "br_lu");
    idle(1, 0, "br_after");

    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "ret0");
    idle(RW + 1, 0, "ret_seq");

    idle(1, 1, "int_rise");
    idle(5, 1, "int_seq");
    idle(1, 0, "int_low");

    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "ret_i");
    idle(1, 1, "ret_irise");
    idle(7, 1, "ret_iseq");
    idle(1, 0, "ret_ilow");

    idle(1, 1, "vec_rise");
    idle(2, 1, "vec_push");
    idle(1, 0, "vec_lo");
    idle(1, 1, "vec_re");
    idle(6, 0, "vec_again");

    idle(1, 1, "r6_rise");
    idle(2, 1, "r6_push");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "r6_rst");
    idle(4, 1, "r6_after");
    idle(1, 0, "r6_low");

    for (int c = 0; c < 800; c++) begin
      bit rst, ld, ua, ub, br, ret, req;
      rst = ($urandom_range(0, 59) != 0);
      ld  = ($urandom_range(0, 3) == 0);
      ua  = $urandom_range(0, 1) == 1;
      ub  = $urandom_range(0, 1) == 1;
      br  = ($urandom_range(0, 7) == 0);
      ret = (m_q.size() == 0) && ($urandom_range(0, 15) == 0);
      req = ($urandom_range(0, 9) == 0) ? !intr_req : intr_req;
      step(rst, ld, 2'($urandom), 2'($urandom), 2'($urandom),
           ua, ub, br, ret, req, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
